// File: rtl/timer_down4_controller_pkg.sv
// rtl/timer_down4_controller_pkg.sv - state type and count helpers for the down-count timer
`include "timer_ctrl_defs.vh"

package timer_down4_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = `TIMER_ST_IDLE,
      ST_RUN    = `TIMER_ST_RUN,
      ST_PAUSED = `TIMER_ST_PAUSED
   } state_t;

   localparam int COUNT_W = 4;

   // Terminal tick: the count is about to reach zero.
   function automatic logic is_terminal(input logic [COUNT_W-1:0] value);
      return value == COUNT_W'(1);
   endfunction

endpackage

// File: rtl/timer_ctrl_defs.vh
// rtl/timer_ctrl_defs.vh - shared state encodings for the down-count timer FSM
`ifndef TIMER_CTRL_DEFS_VH
`define TIMER_CTRL_DEFS_VH

`define TIMER_ST_IDLE   2'd0
`define TIMER_ST_RUN    2'd1
`define TIMER_ST_PAUSED 2'd2

`endif

// File: rtl/timer_down4_controller_prescaler.sv
// rtl/timer_down4_controller_prescaler.sv - clock-cycle prescaler producing decrement ticks
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic Clk,
   input  logic Rst,
   input  logic En,
   input  logic Clear,
   output logic Tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   // Frozen whenever En is low, so a pause resumes mid-period.
   always_ff @(posedge Clk) begin
      if (Rst || Clear) begin
         cnt <= '0;
      end else if (En) begin
         cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
      end
   end

   assign Tick = En && (cnt == LAST);

endmodule

// File: rtl/timer_down4_controller.sv
// rtl/timer_down4_controller.sv - 4-bit down-count timer with pause, abort and auto-reload
module timer_down4_controller
   import timer_down4_controller_pkg::*;
#(
   parameter int PRESCALE = 1,
   parameter int WIDTH    = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             Pause,
   input  logic             Abort,
   input  logic             Reload,
   input  logic [WIDTH-1:0] LoadVal,
   output logic [WIDTH-1:0] count,
   output logic             Busy,
   output logic             Done,
   output logic             Paused
);

   state_t state;
   logic   tick;
   logic   pre_en;
   logic   pre_clear;

   // The resume edge out of PAUSED also advances the prescaler.
   assign pre_en    = !Abort && !Start && !Pause && (state != ST_IDLE);
   assign pre_clear = Abort || Start;

   tick_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .Clk  (Clk),
      .Rst  (Rst),
      .En   (pre_en),
      .Clear(pre_clear),
      .Tick (tick)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= ST_IDLE;
         count <= '0;
         Done  <= 1'b0;
      end else begin
         Done <= 1'b0;
         if (Abort) begin
            state <= ST_IDLE;
            count <= '0;
         end else if (Start) begin
            if (LoadVal != '0) begin
               count <= LoadVal;
               state <= ST_RUN;
            end else begin
               count <= '0;
               state <= ST_IDLE;
               Done  <= 1'b1;
            end
         end else begin
            case (state)
               ST_RUN:    if (Pause)  state <= ST_PAUSED;
               ST_PAUSED: if (!Pause) state <= ST_RUN;
               default:   state <= ST_IDLE;
            endcase
            if (tick) begin
               if (count > WIDTH'(1)) begin
                  count <= count - WIDTH'(1);
               end else if (is_terminal(count) && Reload && (LoadVal != '0)) begin
                  count <= LoadVal;
                  Done  <= 1'b1;
               end else if (is_terminal(count)) begin
                  count <= '0;
                  state <= ST_IDLE;
                  Done  <= 1'b1;
               end else begin
                  // A zero count in RUN cannot normally occur; park without wrapping.
                  state <= ST_IDLE;
               end
            end
         end
      end
   end

   assign Busy   = (state != ST_IDLE);
   assign Paused = (state == ST_PAUSED);

endmodule

// File: tb/tb_timer_down4_controller.sv
// tb/tb_timer_down4_controller.sv - directed self-checking bench for timer_down4_controller
module tb_timer_down4_controller;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       Start = 1'b0;
   logic       Pause = 1'b0;
   logic       Abort = 1'b0;
   logic       Reload = 1'b0;
   logic [3:0] LoadVal = 4'd0;

   logic [3:0] count_a, count_b;
   logic       busy_a, busy_b, done_a, done_b, paused_a, paused_b;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   timer_down4_controller #(.PRESCALE(1), .WIDTH(4)) dut_a (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Pause(Pause), .Abort(Abort),
      .Reload(Reload), .LoadVal(LoadVal), .count(count_a), .Busy(busy_a),
      .Done(done_a), .Paused(paused_a)
   );

   timer_down4_controller #(.PRESCALE(3), .WIDTH(4)) dut_b (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Pause(Pause), .Abort(Abort),
      .Reload(Reload), .LoadVal(LoadVal), .count(count_b), .Busy(busy_b),
      .Done(done_b), .Paused(paused_b)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_a(input string tag, input int c, input int b, input int d, input int p);
      check({tag, ".count"}, int'(count_a), c);
      check({tag, ".busy"}, int'(busy_a), b);
      check({tag, ".done"}, int'(done_a), d);
      check({tag, ".paused"}, int'(paused_a), p);
   endtask

   task automatic do_reset();
      Rst = 1'b1; Start = 1'b0; Pause = 1'b0; Abort = 1'b0; Reload = 1'b0;
      step();
      Rst = 1'b0;
   endtask

   initial begin
      #1;
      step();
      step();
      check_a("reset_a", 0, 0, 0, 0);
      check("reset_b.count", int'(count_b), 0);
      check("reset_b.busy", int'(busy_b), 0);
      Rst = 1'b0;
      step();
      check_a("idle_after_reset", 0, 0, 0, 0);

      // One-shot count of 5 at PRESCALE=1
      LoadVal = 4'd5; Start = 1'b1;
      step();
      Start = 1'b0;
      check_a("oneshot_load", 5, 1, 0, 0);
      for (int i = 4; i >= 0; i--) begin
         step();
         check_a($sformatf("oneshot_%0d", i), i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0, 0);
      end
      step();
      check_a("oneshot_after", 0, 0, 0, 0);

      // Auto-reload of 2 at PRESCALE=3
      do_reset();
      Reload = 1'b1; LoadVal = 4'd2; Start = 1'b1;
      step();
      Start = 1'b0;
      check("reload_load", int'(count_b), 2);
      for (int j = 1; j <= 12; j++) begin
         step();
         check($sformatf("reload_count_%0d", j), int'(count_b), ((j / 3) % 2 == 0) ? 2 : 1);
         check($sformatf("reload_done_%0d", j), int'(done_b), (j % 6 == 0) ? 1 : 0);
         check($sformatf("reload_busy_%0d", j), int'(busy_b), 1);
      end

      // Pause for 7 cycles at count 3
      do_reset();
      LoadVal = 4'd4; Start = 1'b1;
      step();
      Start = 1'b0;
      check_a("pause_load", 4, 1, 0, 0);
      step();
      check_a("pause_pre", 3, 1, 0, 0);
      Pause = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         check_a($sformatf("pause_hold_%0d", i), 3, 1, 0, 1);
      end
      Pause = 1'b0;
      step();
      check_a("pause_resume", 2, 1, 0, 0);
      step();
      check_a("pause_c1", 1, 1, 0, 0);
      step();
      check_a("pause_done", 0, 0, 1, 0);

      // Abort at count 6, then Start+Abort together
      do_reset();
      LoadVal = 4'd9; Start = 1'b1;
      step();
      Start = 1'b0;
      step(); step(); step();
      check_a("abort_pre", 6, 1, 0, 0);
      Abort = 1'b1;
      step();
      Abort = 1'b0;
      check_a("abort", 0, 0, 0, 0);
      step();
      check_a("abort_after", 0, 0, 0, 0);
      Start = 1'b1; Abort = 1'b1;
      step();
      Start = 1'b0; Abort = 1'b0;
      check_a("abort_wins", 0, 0, 0, 0);

      // Abort while paused
      LoadVal = 4'd5; Start = 1'b1;
      step();
      Start = 1'b0; Pause = 1'b1;
      step();
      check_a("pabort_paused", 5, 1, 0, 1);
      Abort = 1'b1;
      step();
      Abort = 1'b0; Pause = 1'b0;
      check_a("pabort", 0, 0, 0, 0);

      // Reset mid-run, then full-range count
      LoadVal = 4'd4; Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      check_a("rst_pre", 3, 1, 0, 0);
      Rst = 1'b1;
      step();
      Rst = 1'b0;
      check_a("rst_mid", 0, 0, 0, 0);
      LoadVal = 4'd15; Start = 1'b1;
      step();
      Start = 1'b0;
      check_a("full_load", 15, 1, 0, 0);
      for (int i = 14; i >= 0; i--) begin
         step();
         check_a($sformatf("full_%0d", i), i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0, 0);
      end
      step();
      check_a("full_no_underflow", 0, 0, 0, 0);

      // Start with zero load, then restart mid-count
      LoadVal = 4'd0; Start = 1'b1;
      step();
      Start = 1'b0;
      check_a("zero_start", 0, 0, 1, 0);
      step();
      check_a("zero_after", 0, 0, 0, 0);
      LoadVal = 4'd3; Start = 1'b1;
      step();
      Start = 1'b0;
      step();
      check_a("restart_pre", 2, 1, 0, 0);
      LoadVal = 4'd7; Start = 1'b1;
      step();
      Start = 1'b0;
      check_a("restart", 7, 1, 0, 0);
      step();
      check_a("restart_next", 6, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
